ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in EX, the requesting end of the stall/flush handshake.
- Accepts a M-extension op from ID/EX and raises busy_o while computing. busy_o is OR'd into the hazard unit's stall request, holding PC, IF/ID and ID/EX.
- Consumes the hazard unit's flush so that a squashed op is abandoned.
- Returns result and rd to the EX/MEM path with a one-cycle done_o pulse.

Parameters:
- XLEN, 32, operand/result width; iteration count of the divider equals XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start_i  input  1  valid M-op present in EX this cycle
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_i  input  XLEN  dividend / multiplicand
- rs2_i  input  XLEN  divisor / multiplier
- rd_addr_i  input  5  destination register
- flush_i  input  1  kill in-flight op (hazard unit id_ex flush)
- busy_o  output  1  stall request to hazard unit
- done_o  output  1  result valid, one-cycle pulse
- result_o  output  XLEN  result
- rd_addr_o  output  5  destination of result

Behaviour:
- Clock, reset: one clock, clk. rst is asynchronous and active-high.
- Reset state: IDLE. done_o=0, result_o=0, rd_addr_o=0, all internal registers 0. busy_o=0 because it is combinational from state.
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, flush_i=0: latch op, operands and rd (cycle T). Next state:
  - MUL for op[2]=0.
  - DIV for op[2]=1.
  - DONE directly if op is a division and a special case holds.
- MUL (T+1): form the 2*XLEN product, with operands sign/zero-extended per op. Register the low half (MUL) or the high half (others). Go to DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles (T+1..T+XLEN). The 6-bit counter counts down from XLEN-1 and goes to DONE when it reaches 0.
- DONE: done_o=1 for exactly one cycle.
  - DIV/REM signs are applied here: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Next state is IDLE.
- Latency from the start cycle T to the done_o cycle:
  - MUL*: T+2.
  - DIV*/REM*: T+XLEN+1 (T+33).
  - Special-case division: T+1.
- busy_o = (state==IDLE & start_i & ~flush_i) | state==MUL | state==DIV. It is deasserted in DONE so the pipeline advances while the result is presented.
- Divide by zero: quotient = all ones (DIV and DIVU); remainder = rs1.
- Signed overflow (rs1=0x80000000, rs2=-1, DIV/REM): quotient 0x80000000, remainder 0.
- flush_i:
  - In MUL or DIV: next state IDLE, no done_o, result_o holds its previous value.
  - In IDLE with start_i: start is ignored.
  - In DONE: done_o still fires; the kill is handled downstream by the pipeline register flush.
- start_i outside IDLE is ignored; the pipeline is stalled, so start_i stays high with the same op.
- A new start is accepted in the cycle after DONE: since the op in EX has advanced, the next op enters at IDLE.
- Reset mid-operation: immediate return to IDLE, all outputs 0.
- result_o and rd_addr_o hold their value after DONE until the next DONE.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE on start of a division, if |rs2| > |rs1| (unsigned magnitudes), go straight to DONE at T+1 with quotient 0 and remainder = rs1. busy_o is asserted only in cycle T.
- Undefined: such divisions take the full XLEN iterations; results are identical.

Test Plan:
- Reset during DIV at iteration 10 -> busy_o=0, done_o=0, state IDLE. Then MUL 7*6 -> done_o at T+2, result_o=42.
- MULH rs1=0x80000000, rs2=0x80000000 -> result_o=0x40000000. MULHSU rs1=-1, rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULHU same operands -> 0xFFFFFFFE.
- DIV rs1=-7, rs2=2 -> busy_o high T..T+32, done_o at T+33, result -3. REM same operands -> -1. DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF at T+1. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000. REM same operands -> 0.
- flush_i at T+5 of a DIV -> IDLE at T+6, no done_o, result_o unchanged. start_i with flush_i in the same cycle -> ignored, busy_o=0.
- MULDIV_EARLY_OUT_EN defined: DIVU 3/10 -> done_o at T+1, result 0. REMU 3/10 -> 3. Undefined: same results at T+33.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit sitting in EX. It raises a stall
//   request while computing, abandons a squashed op on flush and hands the
//   result plus destination register to EX/MEM with a one-cycle done pulse.
//
//   Multiplies take one compute cycle. Divides use a restoring divider on
//   operand magnitudes, one quotient bit per cycle (XLEN cycles), with the
//   signs fixed up on the final iteration. Divide-by-zero and signed
//   overflow bypass the divider and complete one cycle after start.
//
// Configuration macro:
//   MULDIV_EARLY_OUT_EN - when defined, a division whose divisor magnitude
//                         exceeds the dividend magnitude also bypasses the
//                         divider (quotient 0, remainder rs1).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   start_i    valid M-op present in EX this cycle
//   op_i       funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   rs1_i      dividend / multiplicand
//   rs2_i      divisor / multiplier
//   rd_addr_i  destination register of the op
//   flush_i    kill the in-flight op
//   busy_o     stall request to the hazard unit
//   done_o     result valid, one-cycle pulse
//   result_o   result, held until the next done
//   rd_addr_o  destination of result_o
// ----------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [5:0]      CNT_INIT = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg, state_next;
  logic [1:0]      op_reg, op_next;          // funct3[1:0]; funct3[2] is implied by state
  logic [XLEN-1:0] a_reg, a_next;            // multiplicand, or dividend shifting into quotient
  logic [XLEN-1:0] b_reg, b_next;            // multiplier, or divisor magnitude
  logic [XLEN-1:0] rem_reg, rem_next;        // partial remainder
  logic [5:0]      cnt_reg, cnt_next;
  logic            neg_q_reg, neg_q_next;
  logic            neg_r_reg, neg_r_next;
  logic [4:0]      rd_reg, rd_next;
  logic [XLEN-1:0] result_reg, result_next;
  logic [4:0]      rd_out_reg, rd_out_next;

  // Start-cycle decode of a division
  logic            in_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            div_by_zero, div_ovf, early_out, div_special;
  logic [XLEN-1:0] special_res;

  assign in_signed   = ~op_i[0];
  assign rs1_neg     = in_signed & rs1_i[XLEN-1];
  assign rs2_neg     = in_signed & rs2_i[XLEN-1];
  assign rs1_mag     = rs1_neg ? -rs1_i : rs1_i;
  assign rs2_mag     = rs2_neg ? -rs2_i : rs2_i;
  assign div_by_zero = (rs2_i == '0);
  assign div_ovf     = in_signed && (rs1_i == INT_MIN) && (rs2_i == '1);
`ifdef MULDIV_EARLY_OUT_EN
  assign early_out   = (rs2_mag > rs1_mag);
`else
  assign early_out   = 1'b0;
`endif
  assign div_special = div_by_zero | div_ovf | early_out;

  always_comb begin
    special_res = '0;
    if (div_by_zero)  special_res = op_i[1] ? rs1_i : '1;
    else if (div_ovf) special_res = op_i[1] ? '0 : INT_MIN;
    else              special_res = op_i[1] ? rs1_i : '0;
  end

  // Multiplier: sign-extend each operand to 2*XLEN; the low 2*XLEN bits of
  // the product are then correct for every signedness combination.
  logic            mul_s1, mul_s2;
  logic [2*XLEN-1:0] mul_a, mul_b, product;

  assign mul_s1  = ~(op_reg[1] & op_reg[0]);   // signed rs1 except MULHU
  assign mul_s2  = ~op_reg[1];                 // signed rs2 only for MUL/MULH
  assign mul_a   = {{XLEN{mul_s1 & a_reg[XLEN-1]}}, a_reg};
  assign mul_b   = {{XLEN{mul_s2 & b_reg[XLEN-1]}}, b_reg};
  assign product = mul_a * mul_b;

  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor if it fits.
  logic [XLEN:0]   div_shift, div_diff;
  logic            q_bit;
  logic [XLEN-1:0] q_step, r_step, quot_out, rem_out;

  assign div_shift = {rem_reg, a_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign q_bit     = ~div_diff[XLEN];
  assign r_step    = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign q_step    = {a_reg[XLEN-2:0], q_bit};
  assign quot_out  = neg_q_reg ? -q_step : q_step;
  assign rem_out   = neg_r_reg ? -r_step : r_step;

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    rem_next    = rem_reg;
    cnt_next    = cnt_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    rd_next     = rd_reg;
    result_next = result_reg;
    rd_out_next = rd_out_reg;

    case (state_reg)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_next    = op_i[1:0];
          rd_next    = rd_addr_i;
          neg_q_next = rs1_neg ^ rs2_neg;
          neg_r_next = rs1_neg;
          if (!op_i[2]) begin
            a_next     = rs1_i;
            b_next     = rs2_i;
            state_next = S_MUL;
          end else if (div_special) begin
            result_next = special_res;
            rd_out_next = rd_addr_i;
            state_next  = S_DONE;
          end else begin
            a_next     = rs1_mag;
            b_next     = rs2_mag;
            rem_next   = '0;
            cnt_next   = CNT_INIT;
            state_next = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_next = S_IDLE;
        end else begin
          result_next = (op_reg == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
          rd_out_next = rd_reg;
          state_next  = S_DONE;
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_next = S_IDLE;
        end else begin
          a_next   = q_step;
          rem_next = r_step;
          if (cnt_reg == 6'd0) begin
            result_next = op_reg[1] ? rem_out : quot_out;
            rd_out_next = rd_reg;
            state_next  = S_DONE;
          end else begin
            cnt_next = cnt_reg - 6'd1;
          end
        end
      end
      default: state_next = S_IDLE;   // S_DONE: one-cycle result presentation
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      rd_reg     <= '0;
      result_reg <= '0;
      rd_out_reg <= '0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      rem_reg    <= rem_next;
      cnt_reg    <= cnt_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      rd_reg     <= rd_next;
      result_reg <= result_next;
      rd_out_reg <= rd_out_next;
    end
  end

  // Deasserted in DONE so the pipeline advances while the result is shown.
  assign busy_o    = ((state_reg == S_IDLE) && start_i && !flush_i) ||
                     (state_reg == S_MUL) || (state_reg == S_DIV);
  assign done_o    = (state_reg == S_DONE);
  assign result_o  = result_reg;
  assign rd_addr_o = rd_out_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv_unit
//   Directed and randomized bench for ex_muldiv_unit. Expected results and
//   latencies come from a plain-arithmetic RV32M model (64-bit integer
//   multiply/divide). Honours MULDIV_EARLY_OUT_EN for expected latency.
// ----------------------------------------------------------------------------
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_addr_i(rd_addr_i), .flush_i(flush_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .rd_addr_o(rd_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M reference result
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin sp = sa * sb; up = sp; return up[63:32]; end
      3'd2: begin sp = sa * longint'({32'd0, b}); up = sp; return up[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; sp = sa / sb; up = sp; return up[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; sp = sa % sb; up = sp; return up[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  // Cycles from the start cycle to the done cycle
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_OUT_EN
    if (mb > ma) return 1;
`else
    if (mb > ma) return 33;
`endif
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp_r;
    int          exp_lat, k;
    bit          busy_ok;
    exp_r   = ref_result(op, a, b);
    exp_lat = ref_latency(op, a, b);
    @(negedge clk);
    start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b; rd_addr_i = rd;
    #1;
    busy_ok = (busy_o === 1'b1) && (done_o === 1'b0);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      k++;
      if (done_o === 1'b1) break;
      if (busy_o !== 1'b1) busy_ok = 1'b0;
    end
    start_i = 1'b0;
    check("busy_during_op", {31'd0, busy_ok}, 32'd1);
    check("latency", k, exp_lat);
    check("result", result_o, exp_r);
    check("rd_addr", {27'd0, rd_addr_o}, {27'd0, rd});
    check("busy_in_done", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("done_pulse", {31'd0, done_o}, 32'd0);
    $display("op=%0d rs1=0x%08h rs2=0x%08h rd=%0d -> result=0x%08h exp=0x%08h lat=%0d exp_lat=%0d",
             op, a, b, rd, result_o, exp_r, k, exp_lat);
  endtask

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0]  op;
    rst = 1'b1; start_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_addr_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_rd", {27'd0, rd_addr_o}, 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);   // MULH
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);   // MULHSU
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);   // MULHU
    run_op(3'd4, -32'sd7, 32'd2, 5'd4);                 // DIV -7/2
    run_op(3'd6, -32'sd7, 32'd2, 5'd5);                 // REM -7/2
    run_op(3'd5, 32'd100, 32'd7, 5'd6);                 // DIVU
    run_op(3'd7, 32'd100, 32'd7, 5'd7);                 // REMU
    run_op(3'd5, 32'd5, 32'd0, 5'd8);                   // DIVU by zero
    run_op(3'd6, 32'd5, 32'd0, 5'd9);                   // REM by zero
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);  // DIV overflow
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);  // REM overflow
    run_op(3'd5, 32'd3, 32'd10, 5'd12);                 // DIVU small/large
    run_op(3'd7, 32'd3, 32'd10, 5'd13);                 // REMU small/large

    // Flush in the middle of a divide
    prev = result_o;
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd4; rs1_i = 32'd1000; rs2_i = 32'd3; rd_addr_i = 5'd20;
    repeat (5) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    check("flush_done", {31'd0, done_o}, 32'd0);
    start_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(negedge clk);
    check("flush_no_done", {31'd0, done_o}, 32'd0);
    check("flush_result_hold", result_o, prev);
    $display("flush mid-DIV: busy=%0d done=%0d result=0x%08h", busy_o, done_o, result_o);

    // start together with flush is ignored
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd4; rs1_i = 32'd50; rs2_i = 32'd5;
    #1;
    check("startflush_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("startflush_busy_next", {31'd0, busy_o}, 32'd0);
    check("startflush_done", {31'd0, done_o}, 32'd0);
    start_i = 1'b0; flush_i = 1'b0;
    $display("start+flush: busy=%0d done=%0d", busy_o, done_o);

    // Reset at divide iteration 10
    @(negedge clk);
    start_i = 1'b1; op_i = 3'd5; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'd3; rd_addr_i = 5'd21;
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1; start_i = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_rd", {27'd0, rd_addr_o}, 32'd0);
    $display("reset mid-DIV: busy=%0d done=%0d result=0x%08h", busy_o, done_o, result_o);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'd0, 32'd7, 32'd6, 5'd22);                  // MUL after reset

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 100));
        2:       b = -32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op(op, a, b, 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
